// File: rtl/an_code_encoder_seq_pkg.sv
// Shared AN-code constants, FSM state type and word typedefs.
// Also used by the SEC LUT decoder at the receive end of the link.
package an_code_pkg;

  localparam int unsigned AN_A   = 18613;
  localparam int unsigned AN_N_W = 30;
  localparam int unsigned AN_A_W = 15;
  localparam int unsigned AN_W_W = 45;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } an_state_t;

  typedef logic [AN_N_W-1:0] an_word_t;
  typedef logic [AN_W_W-1:0] an_code_t;

endpackage

// File: rtl/an_code_encoder_seq_if.sv
// Valid/ready bus of the AN-code encoder: data word in, codeword out.
// Error-injection controls exist only when ERR_INJECT_EN is defined.
interface an_code_encoder_seq_if
  import an_code_pkg::*;
#(
  parameter int unsigned N_W = AN_N_W,
  parameter int unsigned W_W = AN_W_W
);
  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] N_in;
  logic           out_valid;
  logic           out_ready;
  logic [W_W-1:0] W_out;
`ifdef ERR_INJECT_EN
  logic           inj_en;
  logic           inj_sign;
  logic [5:0]     inj_pos;
`endif

  // Encoder side
  modport slave (
    input  in_valid, N_in, out_ready,
`ifdef ERR_INJECT_EN
    input  inj_en, inj_sign, inj_pos,
`endif
    output in_ready, out_valid, W_out
  );

  // Upstream/downstream side
  modport master (
    output in_valid, N_in, out_ready,
`ifdef ERR_INJECT_EN
    output inj_en, inj_sign, inj_pos,
`endif
    input  in_ready, out_valid, W_out
  );
endinterface

// File: rtl/an_code_encoder_seq_err_inject.sv
// Combinational error-term generator: +2^pos or -2^pos (mod 2^W_W), or 0.
// Used only when ERR_INJECT_EN is defined.
module an_err_inject
  import an_code_pkg::*;
#(
  parameter int unsigned W_W = AN_W_W
) (
  input  logic           en,
  input  logic           sign,
  input  logic [5:0]     pos,
  output logic [W_W-1:0] init
);
  logic [W_W-1:0] pw;

  always_comb begin
    pw   = '0;
    init = '0;
    if (en && (int'(pos) < int'(W_W))) begin
      pw   = W_W'(1) << pos;
      init = sign ? (W_W'(0) - pw) : pw;
    end
  end
endmodule

// File: rtl/an_code_encoder_seq.sv
// Sequential AN-code encoder W = A*N, one bit of A per cycle via shift-add.
// Optional link-test error injection enabled by macro ERR_INJECT_EN.
module an_code_encoder_seq
  import an_code_pkg::*;
#(
  parameter int unsigned A   = AN_A,
  parameter int unsigned N_W = AN_N_W,
  parameter int unsigned A_W = AN_A_W,
  parameter int unsigned W_W = AN_W_W
) (
  input  logic                  clk,
  input  logic                  rst,
  an_code_encoder_seq_if.slave  bus
);
  localparam int unsigned STEP_W = $clog2(A_W);
  localparam logic [A_W-1:0] A_BITS = A_W'(A);

  an_state_t       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [W_W-1:0]  mreg_q, mreg_d;
  logic [W_W-1:0]  acc_q, acc_d;
  logic [W_W-1:0]  init;
  logic [N_W-1:0]  n_in;
  logic            accept;

  assign n_in = bus.N_in;

`ifdef ERR_INJECT_EN
  an_err_inject #(.W_W(W_W)) u_err_inject (
    .en   (bus.inj_en),
    .sign (bus.inj_sign),
    .pos  (bus.inj_pos),
    .init (init)
  );
`else
  assign init = '0;
`endif

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.W_out     = acc_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mreg_d  = mreg_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        if (A_BITS[step_q]) acc_d = acc_q + mreg_q;
        mreg_d = mreg_q << 1;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(A_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = accept ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Load shared by IDLE and DONE accepts; acc starts at the injection term
    if (accept) begin
      mreg_d = W_W'(n_in);
      acc_d  = init;
      step_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      mreg_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mreg_q  <= mreg_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_an_code_encoder_seq.sv
// Directed-vector bench for an_code_encoder_seq (both build variants).
module tb_an_code_encoder_seq;
  import an_code_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  an_code_encoder_seq_if #(.N_W(AN_N_W), .W_W(AN_W_W)) bus ();

  an_code_encoder_seq #(
    .A   (AN_A),
    .N_W (AN_N_W),
    .A_W (AN_A_W),
    .W_W (AN_W_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n, take the accept edge, then count cycles until out_valid
  task automatic send_word(input logic [29:0] n, output int unsigned lat);
    int unsigned waited;
    bus.in_valid = 1'b1;
    bus.N_in     = n;
    waited = 0;
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  int unsigned lat, lat2;
  logic seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.N_in      = '0;
    bus.out_ready = 1'b0;
`ifdef ERR_INJECT_EN
    bus.inj_en    = 1'b0;
    bus.inj_sign  = 1'b0;
    bus.inj_pos   = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_W_out",     64'(bus.W_out),     64'd0);

    send_word(30'd0, lat);
    check("n0_lat", 64'(lat), 64'd15);
    check("n0_W",   64'(bus.W_out), 64'd0);
    drain();
    check("n0_idle_valid", 64'(bus.out_valid), 64'd0);
    check("n0_idle_ready", 64'(bus.in_ready),  64'd1);

    send_word(30'd1, lat);
    check("n1_lat", 64'(lat), 64'd15);
    check("n1_W",   64'(bus.W_out), 64'd18613);
    drain();

    send_word(30'h3FFF_FFFF, lat);
    check("nmax_lat", 64'(lat), 64'd15);
    check("nmax_W",   64'(bus.W_out), 64'd19985556551499);
    drain();

    // Back-pressure: a competing word is offered but must be ignored
    send_word(30'd5, lat);
    check("bp_lat", 64'(lat), 64'd15);
    bus.in_valid = 1'b1;
    bus.N_in     = 30'd99;
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_W",     64'(bus.W_out),     64'd93065);
      check("bp_ready", 64'(bus.in_ready),  64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    drain();
    check("bp_idle_valid", 64'(bus.out_valid), 64'd0);

    // Back-to-back: 9 is accepted in the DONE cycle of 7
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.N_in      = 30'd7;
    tick();
    bus.N_in = 30'd9;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b_lat7",  64'(lat), 64'd15);
    check("b2b_W7",    64'(bus.W_out), 64'd130291);
    check("b2b_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    lat2 = 1;
    while (!bus.out_valid && lat2 < 40) begin
      tick();
      lat2++;
    end
    check("b2b_gap", 64'(lat2), 64'd16);
    check("b2b_W9",  64'(bus.W_out), 64'd167517);
    tick();
    bus.out_ready = 1'b0;
    check("b2b_idle_valid", 64'(bus.out_valid), 64'd0);

    // Reset at step 7 of N=3 drops the word
    bus.in_valid = 1'b1;
    bus.N_in     = 30'd3;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready),  64'd1);
    check("mid_rst_W",     64'(bus.W_out),     64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_out", 64'(seen), 64'd0);
    send_word(30'd2, lat);
    check("post_rst_lat", 64'(lat), 64'd15);
    check("post_rst_W",   64'(bus.W_out), 64'd37226);
    drain();

`ifdef ERR_INJECT_EN
    bus.inj_en = 1'b1; bus.inj_sign = 1'b0; bus.inj_pos = 6'd0;
    send_word(30'd1, lat);
    bus.inj_en = 1'b0;
    check("inj_p0_W", 64'(bus.W_out), 64'd18614);
    drain();

    bus.inj_en = 1'b1; bus.inj_sign = 1'b1; bus.inj_pos = 6'd14;
    send_word(30'd1, lat);
    bus.inj_en = 1'b0;
    check("inj_m14_W", 64'(bus.W_out), 64'd2229);
    drain();

    bus.inj_en = 1'b1; bus.inj_sign = 1'b1; bus.inj_pos = 6'd0;
    send_word(30'd0, lat);
    bus.inj_en = 1'b0;
    check("inj_wrap_W", 64'(bus.W_out), 64'h1FFF_FFFF_FFFF);
    drain();

    bus.inj_en = 1'b1; bus.inj_sign = 1'b0; bus.inj_pos = 6'd50;
    send_word(30'd1, lat);
    bus.inj_en = 1'b0;
    check("inj_oor_W", 64'(bus.W_out), 64'd18613);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
